muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly upstream of the register file write port. It accepts two source operands read from the register file plus a destination index, computes the M-extension operation over a fixed multi-cycle sequence, and presents a one-cycle writeback pulse whose outputs drive the register file's write-enable, write address and write data. The pipeline stalls on `busy`.

## Interface
- No parameters. Datapath is fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_val`  in  32  operand A (multiplicand/dividend)
- `rs2_val`  in  32  operand B (multiplier/divisor)
- `rd_addr`  in  5  destination register index
- `busy`  out  1  operation in flight; upstream must hold the instruction
- `wb_en`  out  1  one-cycle writeback strobe; drives the register file write-enable
- `wb_addr`  out  5  latched `rd_addr`
- `result`  out  32  latched result; stable until next completion
- `illegal`  out  1  one-cycle flag coincident with completion (see Configuration)

## Operation
- States: IDLE, CALC, FINISH.
- IDLE with `start`=1:
  - latch `funct3`, `rd_addr`, and operand magnitudes plus sign flags;
  - clear the 6-bit iteration counter;
  - go to CALC.
- `start` outside IDLE is ignored. Operands are not re-sampled.
- CALC runs one iteration per cycle for exactly 32 cycles, then goes to FINISH.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring algorithm producing a 32-bit quotient and remainder.
- Sign handling:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- FINISH applies sign correction and selects the result:
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Boundary cases, resolved in FINISH with no change in latency:
  - Divisor = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `rs1_val`.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Completion: register `result` and `wb_addr`, then return to IDLE.
  - `wb_en`=1 for that single cycle, unless `wb_addr`=0, in which case it is suppressed.
- Reset at any time, including mid-CALC:
  - state → IDLE; `busy`, `wb_en`, `illegal` → 0; `result` → 0; `wb_addr` → 0; counter cleared.
  - No writeback is produced for the aborted operation.

## Timing
- Edge E0 samples `start`. `busy`=1 from after E0 until after E33.
- Edges E1..E32 perform the 32 iterations (CALC). Edge E33 is FINISH.
- After E33: `wb_en`/`illegal` are valid for one cycle, `busy`=0, and state is IDLE.
- A new `start` may be asserted during the `wb_en` cycle. It is accepted at E34 (back-to-back issue).
- Fixed latency: result visible 33 cycles after the start edge, for all funct3 values and all operand values.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `RV32M_DIV_EN` defined:
  - full divider datapath compiled in;
  - `illegal` is tied to 0.
- `RV32M_DIV_EN` undefined:
  - divider logic is removed;
  - any start with `funct3[2]`=1 bypasses CALC and completes after E1 with `result`=0, `illegal`=1, and `wb_en` suppressed;
  - multiply operations are unchanged.

## Test plan
- MUL, 7 × 0xFFFFFFFD (−3), `rd_addr`=5 → exactly 33 cycles after start: `wb_en`=1 for one cycle, `wb_addr`=5, `result`=0xFFFFFFEB; `busy` drops in the same cycle.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide and remainder: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Corner cases:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0;
  - MUL with `rd_addr`=0 → `wb_en` stays 0.
- Protocol:
  - `start` pulsed at cycles 3 and 10 of an operation → only the first completes, with the first operand set.
  - `reset` at cycle 10 → next cycle `busy`=0 and `result`=0; no `wb_en` ever appears.
  - Back-to-back start in the `wb_en` cycle → second completes 33 cycles later.
- With `RV32M_DIV_EN` undefined: DIV 10 / 2 → after 1 cycle `illegal`=1, `result`=0, `wb_en`=0; a following MUL 3 × 4 → 12 with `illegal`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring-divide core feeding a register-file writeback pulse.
// Optional macro RV32M_DIV_EN compiles in the divider; without it, divide ops complete early as illegal.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] result,
    output logic        illegal
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic [4:0]  rd_q;
    logic        neg_a, neg_b;
    logic [31:0] a_q;
    logic [63:0] acc;
`ifdef RV32M_DIV_EN
    logic [31:0] b_q;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        div_ge;
    logic [31:0] q_s, r_s, a_orig;
`endif

    logic        in_signed_a, in_signed_b, in_neg_a, in_neg_b;
    logic [31:0] in_a_mag, in_b_mag;
    logic [32:0] mul_sum;
    logic [63:0] acc_step, prod;
    logic [31:0] mul_res, fin_result;
    logic        busy_d, wb_en_d, illegal_d;
    logic [4:0]  wb_addr_d;
    logic [31:0] result_d;

    // Operand sign interpretation by funct3: MULHSU is signed*unsigned, the U forms are fully unsigned.
    always_comb begin
        in_signed_a = 1'b0;
        in_signed_b = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin in_signed_a = 1'b1; in_signed_b = 1'b1; end
            3'b010:                         in_signed_a = 1'b1;
            default: ;
        endcase
        in_neg_a = in_signed_a & rs1_val[31];
        in_neg_b = in_signed_b & rs2_val[31];
        in_a_mag = in_neg_a ? (~rs1_val + 32'd1) : rs1_val;
        in_b_mag = in_neg_b ? (~rs2_val + 32'd1) : rs2_val;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef RV32M_DIV_EN
                state_next = S_CALC;
`else
                state_next = funct3[2] ? S_FINISH : S_CALC;
`endif
            end
            S_CALC:   if (cnt == 6'd31) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // acc holds {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
        acc_step = {mul_sum, acc[31:1]};
`ifdef RV32M_DIV_EN
        rem_sh  = {acc[63:32], acc[31]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        rem_sub = rem_sh[31:0] - b_q;
        if (op[2]) acc_step = {(div_ge ? rem_sub : rem_sh[31:0]), acc[30:0], div_ge};
`endif
    end

    always_comb begin
        prod    = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
        mul_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
`ifdef RV32M_DIV_EN
        // INT_MIN / -1 needs no special case: the magnitude 0x80000000 negates to itself, remainder is 0.
        q_s    = (neg_a ^ neg_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
        r_s    = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
        a_orig = neg_a ? (~a_q + 32'd1) : a_q;
        if (!op[2])     fin_result = mul_res;
        else if (op[1]) fin_result = (b_q == 32'd0) ? a_orig : r_s;
        else            fin_result = (b_q == 32'd0) ? 32'hFFFF_FFFF : q_s;
`else
        fin_result = op[2] ? 32'd0 : mul_res;
`endif
    end

    always_comb begin
        busy_d    = (state_next != S_IDLE);
        wb_en_d   = 1'b0;
        illegal_d = 1'b0;
        wb_addr_d = wb_addr;
        result_d  = result;
        if (state == S_FINISH) begin
            wb_addr_d = rd_q;
            result_d  = fin_result;
`ifdef RV32M_DIV_EN
            wb_en_d   = (rd_q != 5'd0);
`else
            wb_en_d   = (rd_q != 5'd0) && !op[2];
            illegal_d = op[2];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            wb_en   <= 1'b0;
            illegal <= 1'b0;
            wb_addr <= 5'd0;
            result  <= 32'd0;
        end else begin
            busy    <= busy_d;
            wb_en   <= wb_en_d;
            illegal <= illegal_d;
            wb_addr <= wb_addr_d;
            result  <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 6'd0;
            op    <= 3'd0;
            rd_q  <= 5'd0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            a_q   <= 32'd0;
            acc   <= 64'd0;
`ifdef RV32M_DIV_EN
            b_q   <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt   <= 6'd0;
                    op    <= funct3;
                    rd_q  <= rd_addr;
                    neg_a <= in_neg_a;
                    neg_b <= in_neg_b;
                    a_q   <= in_a_mag;
`ifdef RV32M_DIV_EN
                    b_q   <= in_b_mag;
                    acc   <= funct3[2] ? {32'd0, in_a_mag} : {32'd0, in_b_mag};
`else
                    acc   <= {32'd0, in_b_mag};
`endif
                end
                S_CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= acc_step;
                end
                default: ;
            endcase
        end
    end

endmodule
